// File: rtl/multi_s2f_hs.sv
// Slow-to-fast multi-bit CDC using a toggle request/acknowledge handshake.
// The source word is held stable in hold_q until the destination acknowledges it.
module multi_s2f_hs #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                  clkb,
    input  logic                  clka,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  valid_in,
    output logic                  busy,
    output logic                  overflow,
    output logic [CNT_WIDTH-1:0]  drop_cnt,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  valid_out,
    input  logic                  ready_out
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    // clka domain state
    logic [DATA_WIDTH-1:0]  hold_q, hold_d;
    logic                   req_tgl_q, req_tgl_d;
    logic                   busy_q, busy_d;
    logic                   overflow_q, overflow_d;
    logic [CNT_WIDTH-1:0]   drop_cnt_q, drop_cnt_d;
    logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;
    logic                   ack_seen_q, ack_seen_d;
    logic                   ack_arrive;

    // clkb domain state
    logic [SYNC_STAGES-1:0] req_sync_q, req_sync_d;
    logic                   req_seen_q, req_seen_d;
    logic [DATA_WIDTH-1:0]  dout_q, dout_d;
    logic                   valid_out_q, valid_out_d;
    logic                   ack_tgl_q, ack_tgl_d;
    logic                   req_new;

    assign ack_arrive = ack_sync_q[SYNC_STAGES-1] ^ ack_seen_q;
    assign req_new    = req_sync_q[SYNC_STAGES-1] ^ req_seen_q;

    always_comb begin
        hold_d     = hold_q;
        req_tgl_d  = req_tgl_q;
        busy_d     = busy_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        ack_seen_d = ack_seen_q;
        ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], ack_tgl_q};

        if (ack_arrive) begin
            busy_d     = 1'b0;
            ack_seen_d = ack_sync_q[SYNC_STAGES-1];
        end

        // An offer on the edge where busy falls still sees busy_q=1 and is dropped.
        if (valid_in) begin
            if (!busy_q) begin
                hold_d    = din;
                req_tgl_d = ~req_tgl_q;
                busy_d    = 1'b1;
            end else begin
                overflow_d = 1'b1;
                if (drop_cnt_q != CNT_MAX) begin
                    drop_cnt_d = drop_cnt_q + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            hold_q     <= '0;
            req_tgl_q  <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
            ack_sync_q <= '0;
            ack_seen_q <= 1'b0;
        end else begin
            hold_q     <= hold_d;
            req_tgl_q  <= req_tgl_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
            ack_sync_q <= ack_sync_d;
            ack_seen_q <= ack_seen_d;
        end
    end

    // hold_q is sampled directly: it cannot change between the request toggle and the ack.
    always_comb begin
        req_sync_d  = {req_sync_q[SYNC_STAGES-2:0], req_tgl_q};
        req_seen_d  = req_seen_q;
        dout_d      = dout_q;
        valid_out_d = valid_out_q;
        ack_tgl_d   = ack_tgl_q;

        if (valid_out_q && ready_out) begin
            valid_out_d = 1'b0;
            ack_tgl_d   = ~ack_tgl_q;
        end

        if (req_new) begin
            dout_d      = hold_q;
            valid_out_d = 1'b1;
            req_seen_d  = req_sync_q[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clkb or posedge rst) begin
        if (rst) begin
            req_sync_q  <= '0;
            req_seen_q  <= 1'b0;
            dout_q      <= '0;
            valid_out_q <= 1'b0;
            ack_tgl_q   <= 1'b0;
        end else begin
            req_sync_q  <= req_sync_d;
            req_seen_q  <= req_seen_d;
            dout_q      <= dout_d;
            valid_out_q <= valid_out_d;
            ack_tgl_q   <= ack_tgl_d;
        end
    end

    assign busy      = busy_q;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;
    assign dout      = dout_q;
    assign valid_out = valid_out_q;

endmodule

// File: doc/multi_s2f_hs.md
# multi_s2f_hs

Parametrised multi-bit clock-domain crossing from a slow source clock (clka) to a fast destination clock (clkb), using a toggle request/acknowledge handshake. Unlike a level-edge sampler, it holds the source word stable until the destination consumes it. It supports destination back-pressure through a valid/ready output, reports busy to the source, and counts words dropped while busy. It sits between slow-domain producers and fast-domain consumers wherever word integrity and loss reporting are required.

## Interface
- DATA_WIDTH, 8, payload width in bits (≥1)
- SYNC_STAGES, 2, synchroniser flops per crossing; legal range 2–4
- CNT_WIDTH, 8, width of the drop counter
- clkb  input  1  fast destination clock
- clka  input  1  slow source clock
- rst  input  1  reset, asynchronous, active-high; clears both domains
- din  input  DATA_WIDTH  source word, clka domain
- valid_in  input  1  word offer, clka domain, sampled every clka edge
- busy  output  1  clka domain; high while a word is in flight
- overflow  output  1  clka domain; sticky, set on first drop
- drop_cnt  output  CNT_WIDTH  clka domain; saturating count of dropped offers
- dout  output  DATA_WIDTH  clkb domain; delivered word
- valid_out  output  1  clkb domain; dout valid
- ready_out  input  1  clkb domain; consumer accepts dout

## Operation
- Source accept: at a clka edge with valid_in=1 and busy=0:
  - hold_reg ← din
  - req_tgl is inverted
  - busy ← 1
- Drop: at a clka edge with valid_in=1 and busy=1:
  - overflow ← 1
  - drop_cnt increments, saturating at all-ones
  - hold_reg is unchanged
- Request crossing: req_tgl passes through SYNC_STAGES clkb flops. A new request is detected when the last stage differs from req_seen.
- On a new request, at the next clkb edge:
  - dout ← hold_reg
  - valid_out ← 1
  - req_seen ← last sync stage
- hold_reg is a multi-bit crossing. It is stable by construction from the toggle until the ack returns; it is not synchronised per bit.
- Consume: at a clkb edge with valid_out=1 and ready_out=1:
  - valid_out ← 0
  - ack_tgl is inverted
- While valid_out=1 and ready_out=0:
  - dout and valid_out hold
  - ack_tgl is unchanged
- Ack crossing: ack_tgl passes through SYNC_STAGES clka flops. When the last stage differs from ack_seen, at that clka edge busy ← 0 and ack_seen is updated.
- Only one word is in flight at a time. A new request can never arrive while valid_out=1.
- Reset (any time, including mid-transfer):
  - all flops in both domains clear
  - the in-flight word is discarded
  - outputs: dout=0, valid_out=0, busy=0, overflow=0, drop_cnt=0
- rst deassertion is synchronised to each clock by the upstream reset controller.

## Timing
- No clock-ratio constraint; correctness relies only on the handshake. The s2f naming reflects the intended use.
- Accept edge: busy is high from the clka edge that accepts valid_in.
- Request latency: count the first clkb edge that samples the new req_tgl as edge 1. valid_out rises after clkb edge SYNC_STAGES+1.
- Ack latency: busy falls after clka edge SYNC_STAGES+1, counting from the first clka edge that samples the new ack_tgl.
- Throughput: at most one word per full round trip. With SYNC_STAGES=2 and ready_out tied high, that is ≈3 clkb + ≈3–4 clka cycles.
- valid_in at the same clka edge where busy falls: busy is still 1 at that edge, so the offer is dropped. Accept requires busy=0 before the edge.
- Drop counter at saturation: further drops leave drop_cnt unchanged; overflow stays 1.
- valid_out is a level held until consumed. There is one valid_out pulse per accepted word, never duplicated or lost.

## Test plan
- Reset values: assert rst mid-transfer (busy=1, valid_out=1) → all outputs 0 immediately. After release, the next accepted word arrives correctly and no stale word appears.
- Single word, ready_out=1, SYNC_STAGES=2, clka:clkb = 1:4, din=8'hA5:
  - valid_out rises after clkb edge 3 with dout=8'hA5, for exactly one clkb cycle
  - busy falls ~3 clka edges later
- Back-pressure: ready_out=0 for 20 clkb cycles → dout=8'h3C and valid_out=1 hold, busy stays 1. Raise ready_out → one consume, then busy clears.
- Drop: valid_in on 5 consecutive clka edges with din=1..5 → only 1 is delivered, drop_cnt=4, overflow=1. A later offer after busy=0 delivers correctly.
- Saturation: CNT_WIDTH=2, 6 drops → drop_cnt=3 and holds.
- Stream of 100 random words, offered when busy=0, random ready_out, SYNC_STAGES ∈ {2,3,4}, random clock ratios → output sequence equals input sequence, no loss or duplication.
